// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit -- multicycle shift-add multiply / restoring divide, one bit
// per clock, HI/LO result pair with divide-by-zero pulse.
// Optional: define MULTDIV_UNSIGNED_EN to honour op[0] (multu/divu).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                  c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_signed;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic                 w_accept;
  logic                 w_busy_nxt, w_done_nxt, w_div0_nxt;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_signed = ~op[0];
`else
  logic w_unused_op0;
  assign w_unused_op0 = op[0];
  assign w_signed     = 1'b1;
`endif

  // Operands are iterated as magnitudes; signs are reapplied in FIX.
  assign w_a_neg = w_signed & a[WIDTH-1];
  assign w_b_neg = w_signed & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -a : a;
  assign w_abs_b = w_b_neg ? -b : b;

  // ---------------------------------------------------------------- control
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_div0_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (op[1] && (b == '0)) ? ST_ZERO : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_last) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end
      ST_ZERO: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        w_div0_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      div0    <= w_div0_nxt;
    end
  end

  // --------------------------------------------------------------- datapath
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Shifted remainder needs WIDTH+1 bits; a clear top bit of the trial
  // difference means the subtraction is kept.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mcand};
  assign w_div_step  = {(w_div_trial[WIDTH] ? r_acc[2*WIDTH-2:WIDTH-1]
                                            : w_div_trial[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], ~w_div_trial[WIDTH]};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg & op[1];
            r_cnt    <= '0;
            if (op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_mcand <= w_abs_b;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
              r_mcand <= w_abs_a;
            end
          end
        end
        ST_RUN: begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + c_one;
        end
        ST_FIX: begin
          if (r_is_div) begin
            hi <= w_rem_fix;
            lo <= w_quo_fix;
          end else begin
            hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit producing the HI/LO result pair for the multicycle CPU datapath. It implements signed and unsigned multiply (shift-add) and divide (restoring), one bit per clock, and flags divide-by-zero for the exception path. The control FSM starts it with a one-cycle `start` and waits for `done`. Results are then read from `hi`/`lo` into the HI and LO registers.

## Interface
- `WIDTH`, 32, operand width; `hi`/`lo` are each `WIDTH` bits; legal values 8..64.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `busy`  out  1  high from the accepting edge until `done` rises.
- `done`  out  1  one-cycle completion pulse.
- `div0`  out  1  one-cycle pulse coincident with `done` when a divide had `b==0`.
- `hi`  out  WIDTH  product upper half / remainder.
- `lo`  out  WIDTH  product lower half / quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: iteration counter 0..WIDTH-1.
  - FIX: sign fix-up, result load, `done`.
  - ZERO: divide-by-zero report.
- In IDLE, `start=1` is accepted at the edge (E0):
  - latch `op`, |a|, |b| (magnitudes only for signed ops), the result sign bits and the counter.
  - divide with `b==0`: go to ZERO; otherwise go to RUN.
- RUN, multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator half; shift the 2·WIDTH accumulator right by 1.
- RUN, divide: shift the remainder/quotient pair left by 1, trial-subtract the divisor, keep the result if non-negative, and set the quotient bit.
- RUN exits to FIX after WIDTH iterations.
- FIX:
  - mult: {hi,lo} = 2·WIDTH product, negated if the operand signs differ.
  - div: `lo` = quotient truncated toward zero; `hi` = remainder carrying the dividend's sign.
  - `done`=1, then go to IDLE.
- Signed overflow case: -2^(WIDTH-1) / -1 gives `lo`=0x80000000 and `hi`=0 (for WIDTH=32); no flag is raised.
- ZERO: `done`=1, `div0`=1, `hi`/`lo` unchanged, then go to IDLE.
- `hi`/`lo` hold their value between completions. They are written only in FIX.
- `start` while not in IDLE is ignored; it is not queued.
- Reset, asynchronous and at any time including mid-operation:
  - go to IDLE;
  - `busy`, `done`, `div0` = 0;
  - `hi`, `lo`, accumulator and counter = 0.

## Timing
- Normal operation, accept at E0:
  - RUN iterations occupy edges E1..E_WIDTH.
  - FIX at E_WIDTH+1: `hi`/`lo` update, `done` is high for the cycle after E_WIDTH+1, and `busy` falls at the same edge.
  - Latency is WIDTH+1 clocks (33 for WIDTH=32).
- Divide by zero: `done` and `div0` rise at E1 (latency 1 clock); `busy` is high for one cycle.
- Back-to-back: `start` held high during the `done` cycle is accepted at the next edge, giving no idle gap.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `MULTDIV_UNSIGNED_EN`.
- Defined: `op[0]` selects unsigned (multu/divu) operation as above.
- Undefined:
  - `op[0]` is ignored and every operation is signed;
  - the unsigned operand and fix-up logic is not synthesised;
  - op 01 behaves as 00 and op 11 behaves as 10.

## Test plan
- mult, a=7, b=0xFFFFFFFD (-3) -> `done` 33 clocks after accept; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `div0`=0.
- multu, a=b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Without the macro, the same stimulus -> `hi`=0, `lo`=1 (signed -1·-1).
- div, a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then divu, a=100, b=7 -> `lo`=14, `hi`=2.
- div, a=5, b=0, with `hi`/`lo` preloaded by the previous test -> `done`=`div0`=1 one clock after accept; `hi`/`lo` unchanged.
- Busy and back-to-back handling:
  - pulse `start` (mult 3·4) at cycle 10 of a running divide -> ignored; only the divide result appears.
  - `start` held across `done` -> second operation accepted the next edge; `lo`=12 after a further 33 clocks.
- Reset asserted at iteration 15 of a mult, asynchronously between edges -> all outputs 0 immediately. After release, a new mult 2·3 gives `lo`=6 with normal latency.
